term_cmd_rx: RTL and testbench

- Receive-side companion to the avionics debug terminal transmitter.
- Consumes the AVR USB serial byte stream (rx_data/new_rx_data) and assembles line commands of the form `<letter>[ <decimal>]<CR>`.
- Decodes built-in motor, datalog and reset controls, forwards all other commands to the fabric, and echoes accepted characters back to the terminal.

---
 rtl/term_cmd_rx_pkg.sv | 52 +++++
 rtl/term_cmd_rx_if.sv | 36 +++
 rtl/term_cmd_rx_dec_accum.sv | 46 ++++
 rtl/term_cmd_rx.sv | 191 +++++++++++++++++++
 tb/tb_term_cmd_rx.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/term_cmd_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : term_cmd_pkg
// Purpose  : ASCII constants, parser state encoding and byte classifier
//            shared by the terminal command receiver.
// Revision : 1.0  initial release
// ============================================================================
package term_cmd_pkg;

    localparam logic [7:0] c_CR        = 8'h0D;
    localparam logic [7:0] c_LF        = 8'h0A;
    localparam logic [7:0] c_SP        = 8'h20;
    localparam logic [7:0] c_BS        = 8'h08;
    localparam logic [7:0] c_DEL       = 8'h7F;
    localparam logic [7:0] c_DIGIT_LO  = 8'h30;
    localparam logic [7:0] c_DIGIT_HI  = 8'h39;
    localparam logic [7:0] c_LETTER_LO = 8'h61;
    localparam logic [7:0] c_LETTER_HI = 8'h7A;

    localparam logic [7:0] c_CODE_MOTOR = 8'h6D;  // 'm'
    localparam logic [7:0] c_CODE_DLOG  = 8'h64;  // 'd'
    localparam logic [7:0] c_CODE_RST   = 8'h72;  // 'r'

    localparam int         c_ST_W       = 3;
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_CMD     = 3'd1;
    localparam logic [2:0] c_ST_SEP     = 3'd2;
    localparam logic [2:0] c_ST_ARG     = 3'd3;
    localparam logic [2:0] c_ST_DISCARD = 3'd4;

    typedef enum logic [2:0] {
        CLS_LETTER,
        CLS_DIGIT,
        CLS_SPACE,
        CLS_CR,
        CLS_LF,
        CLS_BS,
        CLS_OTHER
    } byte_class_t;

    function automatic byte_class_t classify(input logic [7:0] b);
        if (b >= c_LETTER_LO && b <= c_LETTER_HI) return CLS_LETTER;
        if (b >= c_DIGIT_LO && b <= c_DIGIT_HI)   return CLS_DIGIT;
        if (b == c_SP)                            return CLS_SPACE;
        if (b == c_CR)                            return CLS_CR;
        if (b == c_LF)                            return CLS_LF;
        if (b == c_BS || b == c_DEL)              return CLS_BS;
        return CLS_OTHER;
    endfunction

endpackage
`default_nettype wire

// File: rtl/term_cmd_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : term_cmd_rx_if
// Purpose  : AVR byte stream in, echo and decoded command outputs.
// Revision : 1.0  initial release
// ============================================================================
interface term_cmd_rx_if #(
    parameter int ARG_BITS = 16
);
    logic [7:0]          rx_data;
    logic                new_rx_data;
    logic                tx_busy;
    logic [7:0]          echo_data;
    logic                new_echo;
    logic                cmd_valid;
    logic [7:0]          cmd_code;
    logic [ARG_BITS-1:0] cmd_arg;
    logic                cmd_has_arg;
    logic                cmd_error;
    logic                motor_arm;
    logic                datalog_en;
    logic                soft_rst;

    modport master (
        output rx_data, new_rx_data, tx_busy,
        input  echo_data, new_echo, cmd_valid, cmd_code, cmd_arg,
               cmd_has_arg, cmd_error, motor_arm, datalog_en, soft_rst
    );

    modport slave (
        input  rx_data, new_rx_data, tx_busy,
        output echo_data, new_echo, cmd_valid, cmd_code, cmd_arg,
               cmd_has_arg, cmd_error, motor_arm, datalog_en, soft_rst
    );
endinterface
`default_nettype wire

// File: rtl/term_cmd_rx_dec_accum.sv
`default_nettype none
// ============================================================================
// Module   : dec_accum
// Purpose  : Decimal argument accumulator with digit count and range check.
// Revision : 1.0  initial release
// ============================================================================
module dec_accum #(
    parameter int ARG_BITS   = 16,
    parameter int MAX_DIGITS = 5,
    parameter int CNT_W      = 3
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_clr,
    input  wire logic                i_load,
    input  wire logic [3:0]          i_digit,
    output logic      [ARG_BITS-1:0] o_value,
    output logic      [CNT_W-1:0]    o_count,
    output logic                     o_ovf
);
    logic [ARG_BITS-1:0] r_value;
    logic [CNT_W-1:0]    r_count;
    logic [ARG_BITS+3:0] w_ext;
    logic [ARG_BITS+3:0] w_sum;
    logic [ARG_BITS+3:0] w_max;

    // arg*10 + d without a multiplier; 4 spare bits hold the worst case.
    assign w_ext = {4'd0, r_value};
    assign w_sum = (w_ext << 3) + (w_ext << 1) + {{ARG_BITS{1'b0}}, i_digit};
    assign w_max = {4'd0, {ARG_BITS{1'b1}}};
    assign o_ovf = (w_sum > w_max) || (r_count >= CNT_W'(MAX_DIGITS));

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_value <= '0;
            r_count <= '0;
        end else if (i_load && !o_ovf) begin
            r_value <= w_sum[ARG_BITS-1:0];
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_value = r_value;
    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/term_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : term_cmd_rx
// Purpose  : Terminal line-command parser with echo and built-in controls.
// Revision : 1.0  initial release
// ============================================================================
module term_cmd_rx
    import term_cmd_pkg::*;
#(
    parameter int ARG_BITS   = 16,
    parameter int MAX_DIGITS = 5
) (
    input wire logic       clk,
    input wire logic       rst,
    term_cmd_rx_if.slave   bus
);
    localparam int c_CNT_W = $clog2(MAX_DIGITS + 2);

    logic [c_ST_W-1:0]   r_state, w_state_next;
    logic [7:0]          r_code;
    byte_class_t         w_cls;
    logic                w_clr, w_load, w_latch_code, w_commit, w_line_err;
    logic [ARG_BITS-1:0] w_value;
    logic [c_CNT_W-1:0]  w_count;
    logic                w_ovf;

    assign w_cls = classify(bus.rx_data);

    dec_accum #(
        .ARG_BITS   (ARG_BITS),
        .MAX_DIGITS (MAX_DIGITS),
        .CNT_W      (c_CNT_W)
    ) u_accum (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_load  (w_load),
        .i_digit (bus.rx_data[3:0]),
        .o_value (w_value),
        .o_count (w_count),
        .o_ovf   (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_code  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_latch_code) r_code <= bus.rx_data;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clr        = 1'b0;
        w_load       = 1'b0;
        w_latch_code = 1'b0;
        w_commit     = 1'b0;
        w_line_err   = 1'b0;
        if (bus.new_rx_data && w_cls != CLS_LF) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_cls == CLS_LETTER) begin
                        w_latch_code = 1'b1;
                        w_clr        = 1'b1;
                        w_state_next = c_ST_CMD;
                    end else if (w_cls == CLS_OTHER || w_cls == CLS_DIGIT) begin
                        w_state_next = c_ST_DISCARD;
                    end
                end
                c_ST_CMD: begin
                    case (w_cls)
                        CLS_SPACE: w_state_next = c_ST_SEP;
                        CLS_CR:    begin w_commit = 1'b1; w_state_next = c_ST_IDLE; end
                        CLS_BS:    w_state_next = c_ST_IDLE;
                        default:   w_state_next = c_ST_DISCARD;
                    endcase
                end
                c_ST_SEP, c_ST_ARG: begin
                    case (w_cls)
                        CLS_DIGIT: begin
                            if (w_ovf) begin
                                w_state_next = c_ST_DISCARD;
                            end else begin
                                w_load       = 1'b1;
                                w_state_next = c_ST_ARG;
                            end
                        end
                        CLS_SPACE: w_state_next = (r_state == c_ST_SEP) ? c_ST_SEP : c_ST_DISCARD;
                        CLS_CR:    begin w_commit = 1'b1; w_state_next = c_ST_IDLE; end
                        CLS_BS:    w_state_next = c_ST_IDLE;
                        default:   w_state_next = c_ST_DISCARD;
                    endcase
                end
                c_ST_DISCARD: begin
                    if (w_cls == CLS_CR) begin
                        w_line_err   = 1'b1;
                        w_state_next = c_ST_IDLE;
                    end
                end
                default: w_state_next = c_ST_IDLE;
            endcase
        end
    end

    // Command outputs: built-in decode and level updates for the commit cycle.
    logic w_has_arg, w_is_lvl, w_lvl_bad;
    logic w_valid_nxt, w_err_nxt, w_srst_nxt, w_motor_nxt, w_dlog_nxt;
    logic r_valid, r_err, r_srst, r_motor, r_dlog, r_has_arg;
    logic [7:0]          r_cmd_code;
    logic [ARG_BITS-1:0] r_arg;

    assign w_has_arg = (w_count != '0);
    assign w_is_lvl  = (r_code == c_CODE_MOTOR) || (r_code == c_CODE_DLOG);
    assign w_lvl_bad = w_has_arg && (w_value > ARG_BITS'(1));

    always_comb begin
        w_valid_nxt = 1'b0;
        w_err_nxt   = w_line_err;
        w_srst_nxt  = 1'b0;
        w_motor_nxt = r_motor;
        w_dlog_nxt  = r_dlog;
        if (w_commit) begin
            if (w_is_lvl && w_lvl_bad) begin
                w_err_nxt = 1'b1;
            end else begin
                w_valid_nxt = 1'b1;
                if (r_code == c_CODE_MOTOR) w_motor_nxt = w_has_arg ? w_value[0] : ~r_motor;
                if (r_code == c_CODE_DLOG)  w_dlog_nxt  = w_has_arg ? w_value[0] : ~r_dlog;
                if (r_code == c_CODE_RST)   w_srst_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_srst     <= 1'b0;
            r_motor    <= 1'b0;
            r_dlog     <= 1'b0;
            r_cmd_code <= '0;
            r_arg      <= '0;
            r_has_arg  <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_srst  <= w_srst_nxt;
            r_motor <= w_motor_nxt;
            r_dlog  <= w_dlog_nxt;
            if (w_valid_nxt) begin
                r_cmd_code <= r_code;
                r_arg      <= w_value;
                r_has_arg  <= w_has_arg;
            end
        end
    end

    // Single-entry echo slot; newest byte overwrites, parsing never waits.
    logic       r_echo_full, w_echo_take, w_echo_fire;
    logic [7:0] r_echo_data;

    assign w_echo_take = bus.new_rx_data && (w_cls != CLS_LF) &&
                         ((r_state != c_ST_DISCARD) || (w_cls == CLS_CR));
    assign w_echo_fire = r_echo_full && !bus.tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_echo_full <= 1'b0;
            r_echo_data <= '0;
        end else if (w_echo_take) begin
            r_echo_full <= 1'b1;
            r_echo_data <= (w_cls == CLS_CR || w_cls == CLS_BS) ? c_CR : bus.rx_data;
        end else if (w_echo_fire) begin
            r_echo_full <= 1'b0;
        end
    end

    assign bus.echo_data   = r_echo_data;
    assign bus.new_echo    = w_echo_fire;
    assign bus.cmd_valid   = r_valid;
    assign bus.cmd_code    = r_cmd_code;
    assign bus.cmd_arg     = r_arg;
    assign bus.cmd_has_arg = r_has_arg;
    assign bus.cmd_error   = r_err;
    assign bus.motor_arm   = r_motor;
    assign bus.datalog_en  = r_dlog;
    assign bus.soft_rst    = r_srst;
endmodule
`default_nettype wire

// File: tb/tb_term_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_term_cmd_rx
// Purpose  : Scoreboard bench for term_cmd_rx with directed command lines.
// Revision : 1.0  initial release
// ============================================================================
module tb_term_cmd_rx;
    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic [15:0] arg;
        bit         has;
        bit         motor;
        bit         dlog;
        bit         srst;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_echo = 1'b1;

    logic [7:0] echo_q[$];
    exp_t       cmd_q[$];

    term_cmd_rx_if #(.ARG_BITS(16)) bus();

    term_cmd_rx #(.ARG_BITS(16), .MAX_DIGITS(5)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic exp_echo(input string s);
        logic [7:0] b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            if (b != 8'h0A) begin
                if (b == 8'h08 || b == 8'h7F) b = 8'h0D;
                echo_q.push_back(b);
            end
        end
    endtask

    task automatic exp_cmd(input logic [7:0] code, input logic [15:0] arg, input bit has,
                           input bit motor, input bit dlog, input bit srst);
        exp_t e;
        e.is_err = 1'b0; e.code = code; e.arg = arg; e.has = has;
        e.motor = motor; e.dlog = dlog; e.srst = srst;
        cmd_q.push_back(e);
    endtask

    task automatic exp_err(input bit motor, input bit dlog);
        exp_t e;
        e.is_err = 1'b1; e.code = 8'h00; e.arg = 16'h0; e.has = 1'b0;
        e.motor = motor; e.dlog = dlog; e.srst = 1'b0;
        cmd_q.push_back(e);
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(posedge clk); #1;
            bus.rx_data     = s[i];
            bus.new_rx_data = 1'b1;
        end
        @(posedge clk); #1;
        bus.new_rx_data = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string name);
        logic [41:0] act;
        act = {bus.echo_data, bus.new_echo, bus.cmd_valid, bus.cmd_code, bus.cmd_arg,
               bus.cmd_has_arg, bus.cmd_error, bus.motor_arm, bus.datalog_en, bus.soft_rst};
        n_tests++;
        if (act !== 42'h0) begin
            n_fail++;
            $display("FAIL %s: outputs got %h required 0", name, act);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an echo or a strobe.
    always @(negedge clk) begin
        exp_t  e;
        logic [7:0] eb;
        bit    ok;
        if (!rst) begin
            if (bus.new_echo === 1'b1 && chk_echo) begin
                n_tests++;
                if (echo_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL echo: got unexpected byte %h, required none", bus.echo_data);
                end else begin
                    eb = echo_q.pop_front();
                    if (bus.echo_data !== eb) begin
                        n_fail++;
                        $display("FAIL echo: got %h required %h", bus.echo_data, eb);
                    end
                end
            end
            if (bus.cmd_valid === 1'b1 || bus.cmd_error === 1'b1 || bus.soft_rst === 1'b1) begin
                n_tests++;
                if (cmd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL cmd: unexpected strobe valid=%b err=%b srst=%b code=%h",
                             bus.cmd_valid, bus.cmd_error, bus.soft_rst, bus.cmd_code);
                end else begin
                    e = cmd_q.pop_front();
                    if (e.is_err)
                        ok = (bus.cmd_error === 1'b1) && (bus.cmd_valid === 1'b0) &&
                             (bus.soft_rst === 1'b0) && (bus.motor_arm === e.motor) &&
                             (bus.datalog_en === e.dlog);
                    else
                        ok = (bus.cmd_valid === 1'b1) && (bus.cmd_error === 1'b0) &&
                             (bus.cmd_code === e.code) && (bus.cmd_arg === e.arg) &&
                             (bus.cmd_has_arg === e.has) && (bus.motor_arm === e.motor) &&
                             (bus.datalog_en === e.dlog) && (bus.soft_rst === e.srst);
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL cmd: got v=%b e=%b code=%h arg=%0d has=%b m=%b d=%b sr=%b required e=%b code=%h arg=%0d has=%b m=%b d=%b sr=%b",
                                 bus.cmd_valid, bus.cmd_error, bus.cmd_code, bus.cmd_arg,
                                 bus.cmd_has_arg, bus.motor_arm, bus.datalog_en, bus.soft_rst,
                                 e.is_err, e.code, e.arg, e.has, e.motor, e.dlog, e.srst);
                    end
                end
            end
        end
    end

    initial begin
        bus.rx_data     = 8'h00;
        bus.new_rx_data = 1'b0;
        bus.tx_busy     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_outputs("reset");

        // Plain toggles of the motor level
        exp_echo("m\015"); exp_cmd(8'h6D, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        send("m\015"); drain();
        exp_echo("m\015"); exp_cmd(8'h6D, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        send("m\015"); drain();

        // Forwarded argument and datalog level
        exp_echo("p 1500\015"); exp_cmd(8'h70, 16'd1500, 1'b1, 1'b0, 1'b0, 1'b0);
        send("p 1500\015"); drain();
        exp_echo("d 1\015"); exp_cmd(8'h64, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        send("d 1\015"); drain();
        exp_echo("d 7\015"); exp_err(1'b0, 1'b1);
        send("d 7\015"); drain();

        // Range and digit-count limits
        exp_echo("x 65535\015"); exp_cmd(8'h78, 16'd65535, 1'b1, 1'b0, 1'b1, 1'b0);
        send("x 65535\015"); drain();
        chk_echo = 1'b0;
        exp_err(1'b0, 1'b1); send("x 65536\015");  drain();
        exp_err(1'b0, 1'b1); send("x 123456\015"); drain();
        exp_err(1'b0, 1'b1); send("5x\015");       drain();
        chk_echo = 1'b1;

        // Leading spaces, backspace edits, empty lines
        exp_echo("  a\015"); exp_cmd(8'h61, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        send("  a\015"); drain();
        exp_echo("a\010c\015"); exp_cmd(8'h63, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        send("a\010c\015"); drain();
        exp_echo("b\177e 0\015"); exp_cmd(8'h65, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        send("b\177e 0\015"); drain();
        exp_echo("\015"); send("\015"); drain();
        send("\012"); drain();

        // Soft reset ignores its argument; motor set by value, bad value rejected
        exp_echo("r 9\015"); exp_cmd(8'h72, 16'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        send("r 9\015"); drain();
        exp_echo("m 1\015"); exp_cmd(8'h6D, 16'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        send("m 1\015"); drain();
        exp_echo("m 2\015"); exp_err(1'b1, 1'b1);
        send("m 2\015"); drain();

        // Echo back-pressure: only the last byte survives, commands unaffected
        bus.tx_busy = 1'b1;
        exp_cmd(8'h71, 16'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        send("q 4\015"); drain();
        exp_echo("\015");
        bus.tx_busy = 1'b0;
        drain();

        // Reset mid-line drops the partial line, pending echo and levels
        bus.tx_busy = 1'b1;
        send("k 12"); drain();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_idle_outputs("midline_reset");
        bus.tx_busy = 1'b0;
        drain();
        exp_echo("\015"); send("\015"); drain();

        n_tests++;
        if (echo_q.size() != 0) begin
            n_fail++;
            $display("FAIL echo_drain: got %0d pending required 0", echo_q.size());
        end
        n_tests++;
        if (cmd_q.size() != 0) begin
            n_fail++;
            $display("FAIL cmd_drain: got %0d pending required 0", cmd_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
